// File: rtl/case_2_mul_arbiter_pkg.sv
// Shared defaults and helpers for the multiplier arbiter.
package case_2_mul_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_W_DEF     = 6;
  localparam int B_W_DEF     = 4;
  localparam int P_W_DEF     = 8;
  localparam int CNT_W       = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/case_2_mul_6s_4s_8_1_1.sv
// Combinational signed multiplier, result truncated to P_W bits.
module case_2_mul_6s_4s_8_1_1
  import case_2_mul_arbiter_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int P_W = P_W_DEF
) (
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [P_W-1:0] p_o
);

  // The low P_W bits of a two's-complement product depend only on the low
  // P_W bits of each operand, so sizing both operands to P_W (sign-extending
  // or truncating) and multiplying at P_W gives the wrapped result directly.
  assign p_o = P_W'(a_i) * P_W'(b_i);

endmodule

// File: rtl/case_2_mul_arbiter.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters,
// with a single registered output slot and an accepted-operation counter.
module case_2_mul_arbiter
  import case_2_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*A_W-1:0]       req_a,
  input  logic [NUM_REQ*B_W-1:0]       req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [id_w(NUM_REQ)-1:0]     rsp_id,
  output logic [P_W-1:0]               rsp_p,
  input  logic                         rsp_ready,
  output logic [CNT_W-1:0]             issue_cnt
);

  localparam int ID_W = id_w(NUM_REQ);

  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q,    rsp_id_d;
  logic [P_W-1:0]       rsp_p_q,     rsp_p_d;
  logic [ID_W-1:0]      ptr_q,       ptr_d;
  logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;

  logic                 found;
  logic [ID_W-1:0]      grant_idx;
  logic                 can_accept;
  logic                 accept;
  logic signed [A_W-1:0] a_sel;
  logic signed [B_W-1:0] b_sel;
  logic signed [P_W-1:0] mul_p;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    int unsigned idx;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign can_accept = !rsp_valid_q || rsp_ready;
  // Reset gates the handshake so nothing is accepted during the reset cycle.
  assign accept     = found && can_accept && !ap_rst;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // Only the granted requester's operands reach the shared multiplier.
  assign a_sel = $signed(req_a[grant_idx*A_W +: A_W]);
  assign b_sel = $signed(req_b[grant_idx*B_W +: B_W]);

  case_2_mul_6s_4s_8_1_1 #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mul (
    .a_i (a_sel),
    .b_i (b_sel),
    .p_o (mul_p)
  );

  // Next-state: load the slot on accept, otherwise drain it when taken.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_p_d     = mul_p;
      ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      issue_cnt_d = issue_cnt_q + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (ap_rst) begin
      // NOTE: the data register rsp_p is reset too, because its value right
      // after reset is observable at the port and must read as zero.
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      ptr_q       <= '0;
      issue_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_case_2_mul_arbiter.sv
// Self-checking bench for case_2_mul_arbiter: directed vector table, corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_case_2_mul_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int BW = 4;
  localparam int PW = 8;
  localparam int IW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic            ap_rst2;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            rsp_ready;

  logic [N-1:0]    req_ready,   req_ready_2;
  logic            rsp_valid,   rsp_valid_2;
  logic [IW-1:0]   rsp_id,      rsp_id_2;
  logic [PW-1:0]   rsp_p,       rsp_p_2;
  logic [15:0]     issue_cnt,   issue_cnt_2;

  case_2_mul_arbiter #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready),
    .issue_cnt(issue_cnt)
  );

  // Second instance shares all stimulus except reset, so one long counter
  // ramp serves both the reset-at-0xFFFF and the wrap-at-0xFFFF scenarios.
  case_2_mul_arbiter #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) u_dut2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst2), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready_2), .rsp_valid(rsp_valid_2),
    .rsp_id(rsp_id_2), .rsp_p(rsp_p_2), .rsp_ready(rsp_ready),
    .issue_cnt(issue_cnt_2)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, kept as plain integers.
  bit          m_valid;
  int          m_id;
  int          m_ptr;
  logic [PW-1:0] m_p;
  int          m_cnt;
  bit          chk_en;

  typedef struct {
    int          a;
    int          b;
    logic [7:0]  p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int opa(input int i);
    logic [AW-1:0] v;
    v = req_a[i*AW +: AW];
    return int'($signed(v));
  endfunction

  function automatic int opb(input int i);
    logic [BW-1:0] v;
    v = req_b[i*BW +: BW];
    return int'($signed(v));
  endfunction

  function automatic logic [PW-1:0] model_prod(input int a, input int b);
    int full;
    full = a * b;
    return PW'(full);
  endfunction

  task automatic set_rst(input bit v);
    ap_rst  = v;
    ap_rst2 = v;
  endtask

  task automatic rand_ops();
    req_a = N*AW'($urandom);
    req_b = N*BW'($urandom);
  endtask

  // One clock: compare against the model, then advance the model by the rules
  // (round-robin grant, single slot, 1-cycle latency, 16-bit wrapping count).
  task automatic cycle();
    int g;
    int idx;
    logic [N-1:0] exp_rdy;
    bit n_valid;
    int n_id, n_ptr, n_cnt;
    logic [PW-1:0] n_p;
    #1;
    g = -1;
    exp_rdy = '0;
    if (!ap_rst && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
      if (m_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_p",  32'(rsp_p),  32'(m_p));
      end
    end
    n_valid = m_valid; n_id = m_id; n_p = m_p; n_ptr = m_ptr; n_cnt = m_cnt;
    if (ap_rst) begin
      n_valid = 0; n_id = 0; n_p = '0; n_ptr = 0; n_cnt = 0;
    end else if (g >= 0) begin
      n_valid = 1;
      n_id    = g;
      n_p     = model_prod(opa(g), opb(g));
      n_ptr   = (g + 1) % N;
      n_cnt   = (m_cnt + 1) % 65536;
    end else if (rsp_ready) begin
      n_valid = 0;
    end
    @(posedge ap_clk);
    m_valid = n_valid; m_id = n_id; m_p = n_p; m_ptr = n_ptr; m_cnt = n_cnt;
    @(negedge ap_clk);
  endtask

  initial begin
    vec_t vecs[8];
    logic [IW-1:0] held_id;
    logic [PW-1:0] held_p;
    int guard;
    int save_ptr;
    logic [PW-1:0] exp_p2;

    vecs[0] = '{a:  31, b:  7, p: 8'hD9};
    vecs[1] = '{a: -32, b: -8, p: 8'h00};
    vecs[2] = '{a:  -1, b:  1, p: 8'hFF};
    vecs[3] = '{a: -32, b:  7, p: 8'h20};
    vecs[4] = '{a:  31, b: -8, p: 8'h08};
    vecs[5] = '{a:   0, b:  5, p: 8'h00};
    vecs[6] = '{a:  -5, b: -3, p: 8'h0F};
    vecs[7] = '{a:  10, b:  3, p: 8'h1E};

    m_valid = 0; m_id = 0; m_ptr = 0; m_p = '0; m_cnt = 0;
    chk_en = 0;
    set_rst(1'b1);
    req_valid = '1;
    rand_ops();
    rsp_ready = 1'b0;
    @(negedge ap_clk);
    cycle();
    chk_en = 1;
    cycle();
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id",    32'(rsp_id),    32'd0);
    check("reset rsp_p",     32'(rsp_p),     32'd0);
    check("reset issue_cnt", 32'(issue_cnt), 32'd0);

    // Directed product table on requester 0 with the sink always ready.
    set_rst(1'b0);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      req_a[0 +: AW] = AW'(vecs[i].a);
      req_b[0 +: BW] = BW'(vecs[i].b);
      cycle();
      check("vec rsp_valid", 32'(rsp_valid), 32'd1);
      check("vec rsp_id",    32'(rsp_id),    32'd0);
      check("vec rsp_p",     32'(rsp_p),     32'(vecs[i].p));
      if (i == 0) check("vec issue_cnt", 32'(issue_cnt), 32'd1);
    end
    req_valid = '0;
    cycle();

    // All requesters continuously valid: strict rotation, one result/cycle.
    set_rst(1'b1);
    cycle();
    set_rst(1'b0);
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cycle();
      check("rr rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr rsp_id",    32'(rsp_id),    32'(i % N));
    end

    // Back-pressure with a full slot: output frozen, no grants, ptr held.
    rsp_ready = 1'b0;
    held_id = rsp_id;
    held_p  = rsp_p;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      #1 check("stall req_ready", 32'(req_ready), 32'd0);
      cycle();
      check("stall rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall rsp_id",    32'(rsp_id),    32'(held_id));
      check("stall rsp_p",     32'(rsp_p),     32'(held_p));
    end
    rsp_ready = 1'b1;
    #1 check("unstall req_ready", 32'(req_ready), 32'b0001);
    cycle();
    check("unstall rsp_valid", 32'(rsp_valid), 32'd1);
    check("unstall rsp_id",    32'(rsp_id),    32'd0);

    // Sparse requesters 1 and 3 with ptr at 2: grant 3, then 1.
    req_valid = '0;
    set_rst(1'b1);
    cycle();
    set_rst(1'b0);
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b1010;
    #1 check("sparse first grant", 32'(req_ready), 32'b1000);
    cycle();
    check("sparse first id", 32'(rsp_id), 32'd3);
    #1 check("sparse second grant", 32'(req_ready), 32'b0010);
    cycle();
    check("sparse second id", 32'(rsp_id), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req_valid = N'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      set_rst($urandom_range(0, 99) == 0);
      cycle();
    end

    // Ramp issue_cnt to 0xFFFF on both instances.
    set_rst(1'b1);
    cycle();
    set_rst(1'b0);
    req_valid = '1;
    rsp_ready = 1'b1;
    guard = 0;
    while (m_cnt != 65535 && guard < 70000) begin
      rand_ops();
      cycle();
      guard++;
    end
    check("ramp reached 0xFFFF", 32'(issue_cnt), 32'hFFFF);

    // Reset instance 1 with a pending result; instance 2 accepts and wraps.
    rand_ops();
    save_ptr = m_ptr;
    exp_p2   = model_prod(opa(save_ptr), opb(save_ptr));
    ap_rst   = 1'b1;
    #1 check("dut2 grant at 0xFFFF", 32'(req_ready_2), 32'(1 << save_ptr));
    cycle();
    check("rst rsp_valid",   32'(rsp_valid), 32'd0);
    check("rst rsp_id",      32'(rsp_id),    32'd0);
    check("rst rsp_p",       32'(rsp_p),     32'd0);
    check("rst issue_cnt",   32'(issue_cnt), 32'd0);
    check("wrap issue_cnt",  32'(issue_cnt_2), 32'd0);
    check("wrap rsp_valid",  32'(rsp_valid_2), 32'd1);
    check("wrap rsp_id",     32'(rsp_id_2),    32'(save_ptr));
    check("wrap rsp_p",      32'(rsp_p_2),     32'(exp_p2));
    ap_rst    = 1'b0;
    req_valid = 4'b0110;
    #1 check("post-rst grant", 32'(req_ready), 32'b0010);
    cycle();
    check("post-rst rsp_id", 32'(rsp_id), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/case_2_mul_arbiter.md
CASE_2_MUL_ARBITER -- requirements
Module: case_2_mul_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter A_W, default 6, giving the signed operand A width.
REQ-003 The block SHALL have parameter B_W, default 4, giving the signed operand B width.
REQ-004 The block SHALL have parameter P_W, default 8, giving the result width.
REQ-005 The block SHALL have port ap_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 The block SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-008 The block SHALL have port req_a, input, NUM_REQ*A_W bits: packed signed A operands, requester i at slice i.
REQ-009 The block SHALL have port req_b, input, NUM_REQ*B_W bits: packed signed B operands, requester i at slice i.
REQ-010 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, at most one bit high.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the requester owning the result.
REQ-013 The block SHALL have port rsp_p, output, P_W bits: signed product.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: downstream accept.
REQ-015 The block SHALL have port issue_cnt, output, 16 bits: count of accepted operations.

Function
REQ-016 The block SHALL share one signed A_W x B_W multiplier among all requesters.
REQ-017 rsp_p SHALL equal the low P_W bits of the two's-complement product, truncated (wraps) with no saturation.
REQ-018 The output slot SHALL be a single register, with can_accept = !rsp_valid || rsp_ready.
REQ-019 Grant SHALL be round-robin: the first asserted req_valid at or after pointer ptr, searching upward modulo NUM_REQ.
REQ-020 req_ready[i] SHALL be high only when can_accept is high and i is the granted index; it is combinational from req_valid, ptr and the slot state, and is not a function of req_a/req_b.
REQ-021 Accept SHALL occur on a cycle with req_valid[i] && req_ready[i]; on the next edge rsp_valid=1 and rsp_id=i, and rsp_p holds the product of that cycle's operands (1-cycle latency).
REQ-022 After an accept, ptr SHALL load (i+1) mod NUM_REQ; on cycles with no accept, ptr SHALL hold.
REQ-023 When rsp_valid && rsp_ready and there is no new accept, rsp_valid SHALL clear on the next edge.
REQ-024 When rsp_ready is high with a new accept in the same cycle, the slot SHALL reload back-to-back, sustaining 1 result/cycle.
REQ-025 While rsp_valid && !rsp_ready, rsp_valid, rsp_id and rsp_p SHALL be stable and all req_ready SHALL be 0.
REQ-026 Requester operands SHALL be sampled only on the accept cycle; a requester dropping valid before ready loses nothing.
REQ-027 issue_cnt SHALL increment by 1 per accept and wrap from 0xFFFF to 0x0000.
REQ-028 No requester SHALL wait more than NUM_REQ-1 accepts while continuously valid.

Reset
REQ-029 While ap_rst is high at a clock edge, the block SHALL set rsp_valid=0, rsp_id=0, rsp_p=0, ptr=0 and issue_cnt=0, with req_ready all 0 during the reset cycle.
REQ-030 An ap_rst asserted while a result is pending SHALL discard that result; no partial response appears after reset releases.
REQ-031 The first grant after reset SHALL start its search at requester 0.

Structure
REQ-032 The shared package SHALL hold the default widths (A_W, B_W, P_W, NUM_REQ) and the id-width function.
REQ-033 The multiplier SHALL be one sub-module instance, case_2_mul_6s_4s_8_1_1, combinational, with parameters overridden to A_W/B_W/P_W.
REQ-034 The round-robin arbiter SHALL be inline logic; the design stays within 120-400 lines of RTL.

Verification
REQ-035 Bench scenario: single requester 0 sends a=31, b=7 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_p=0xD9, issue_cnt=1.
REQ-036 Bench scenario: wrap cases a=-32, b=-8 -> rsp_p=0x00; a=-1, b=1 -> rsp_p=0xFF; a=-32, b=7 -> rsp_p=0x20.
REQ-037 Bench scenario: all 4 requesters continuously valid with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,... at one result per cycle.
REQ-038 Bench scenario: rsp_ready=0 for 5 cycles with the slot full -> rsp_* stable, req_ready=0, ptr unchanged; first rsp_ready=1 cycle both drains and accepts the next request.
REQ-039 Bench scenario: only requesters 1 and 3 valid with ptr=2 -> grant 3 first, then 1.
REQ-040 Bench scenario: ap_rst pulsed while rsp_valid=1 and issue_cnt=0xFFFF -> all outputs 0 next cycle and the first grant goes to the lowest valid index; separately, an accept at 0xFFFF without reset wraps issue_cnt to 0x0000.
